bit_packer: RTL and testbench

Variable-length bit-field packer: accepts fields of 0–15 bits per cycle and packs them MSB-first into 32-bit words for downstream storage or transmission. It is the write side of the 32-bit-word bitstream interface. The matching bit-reader accepts 32-bit words and returns requested fields of up to 15 bits. The block has a 47-bit accumulator, a small output word FIFO, a flush path for partial words, and valid/stop handshakes on both sides.

---
 rtl/bit_packer_pkg.sv | 31 +++
 rtl/bit_packer_word_fifo.sv | 51 +++++
 rtl/bit_packer.sv | 134 +++++++++++++
 tb/tb_bit_packer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_packer_pkg.sv
// Shared constants, FIFO entry layout and field helpers for the bit_packer
// bitstream writer.
package bit_packer_pkg;

  localparam int FIELD_W = 15;
  localparam int LEN_W   = 4;
  localparam int WORD_W  = 32;
  localparam int ACC_W   = 47;
  localparam int CNT_W   = 6;
  localparam int ENTRY_W = WORD_W + CNT_W;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  bits;
  } fifo_entry_t;

  // Keep only the low len bits of a field.
  function automatic logic [FIELD_W-1:0] mask_field(input logic [FIELD_W-1:0] data,
                                                    input logic [LEN_W-1:0]   len);
    logic [FIELD_W:0] m;
    m = (17'(1) << len) - 17'(1);
    return data & m[FIELD_W-1:0];
  endfunction

  // Zero everything below the top `bits` bits of a word.
  function automatic logic [WORD_W-1:0] pad_word(input logic [WORD_W-1:0] w,
                                                 input logic [CNT_W-1:0]  bits);
    return w & ~({WORD_W{1'b1}} >> bits);
  endfunction

endpackage

// File: rtl/bit_packer_word_fifo.sv
// Synchronous word FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable without a separate counter.
module word_fifo #(
  parameter int WIDTH = 38,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/bit_packer.sv
// Packs 0..15-bit fields MSB-first into 32-bit words through a word FIFO.
// Define BIT_PACKER_ERR_EN to add a sticky errout for pushes during stall.
module bit_packer
  import bit_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               pushin,
  input  logic [LEN_W-1:0]   lenin,
  input  logic [FIELD_W-1:0] datain,
  input  logic               flushin,
  output logic               stopout,
  input  logic               stopin,
  output logic               pushout,
  output logic [WORD_W-1:0]  dataout,
  output logic [CNT_W-1:0]   bitsout
`ifdef BIT_PACKER_ERR_EN
  ,
  output logic               errout
`endif
);

  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               pushout_q;
  logic [WORD_W-1:0]  dataout_q;
  logic [CNT_W-1:0]   bitsout_q;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  fifo_entry_t        wentry, rentry;
  logic               accept, have_word;
  logic [FIELD_W-1:0] field;
  logic [CNT_W-1:0]   shamt;

  assign have_word = (cnt_q >= CNT_W'(WORD_W));
  assign stopout   = have_word | pend_q;
  assign accept    = pushin & ~stopout;
  assign field     = mask_field(datain, lenin);
  // New field lands directly below the cnt bits already held at the top.
  assign shamt     = CNT_W'(ACC_W) - cnt_q - CNT_W'(lenin);

  always_comb begin
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q | flushin;
    fifo_push = 1'b0;
    wentry    = '0;
    if (have_word) begin
      if (!fifo_full) begin
        fifo_push   = 1'b1;
        wentry.data = acc_q[ACC_W-1 -: WORD_W];
        wentry.bits = CNT_W'(WORD_W);
        acc_d       = acc_q << WORD_W;
        cnt_d       = cnt_q - CNT_W'(WORD_W);
      end
    end else if (pend_q) begin
      if (cnt_q == '0) begin
        pend_d = flushin;
      end else if (!fifo_full) begin
        fifo_push   = 1'b1;
        wentry.data = pad_word(acc_q[ACC_W-1 -: WORD_W], cnt_q);
        wentry.bits = cnt_q;
        acc_d       = '0;
        cnt_d       = '0;
        pend_d      = flushin;
      end
    end else if (accept) begin
      acc_d = acc_q | (ACC_W'(field) << shamt);
      cnt_d = cnt_q + CNT_W'(lenin);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  word_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (wentry),
    .rdata_o (rentry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Output register: pops the FIFO head whenever downstream is not stalling.
  assign fifo_pop = ~stopin & ~fifo_empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      pushout_q <= 1'b0;
      dataout_q <= '0;
      bitsout_q <= '0;
    end else begin
      pushout_q <= fifo_pop;
      if (fifo_pop) begin
        dataout_q <= rentry.data;
        bitsout_q <= rentry.bits;
      end
    end
  end

  assign pushout = pushout_q;
  assign dataout = dataout_q;
  assign bitsout = bitsout_q;

`ifdef BIT_PACKER_ERR_EN
  logic err_q;

  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_q | (pushin & stopout);
  end

  assign errout = err_q;
`endif

endmodule

// File: tb/tb_bit_packer.sv
// Directed testbench for bit_packer; emitted words are collected by a monitor
// and compared against hand-computed values in each scenario task.
module tb_bit_packer;

  logic        clock = 1'b0;
  logic        reset;
  logic        pushin;
  logic [3:0]  lenin;
  logic [14:0] datain;
  logic        flushin;
  logic        stopout;
  logic        stopin;
  logic        pushout;
  logic [31:0] dataout;
  logic [5:0]  bitsout;
`ifdef BIT_PACKER_ERR_EN
  logic        errout;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] q_data[$];
  logic [5:0]  q_bits[$];

  always #5 clock = ~clock;

  bit_packer #(.FIFO_DEPTH(4)) dut (
    .clock   (clock),
    .reset   (reset),
    .pushin  (pushin),
    .lenin   (lenin),
    .datain  (datain),
    .flushin (flushin),
    .stopout (stopout),
    .stopin  (stopin),
    .pushout (pushout),
    .dataout (dataout),
    .bitsout (bitsout)
`ifdef BIT_PACKER_ERR_EN
    ,
    .errout  (errout)
`endif
  );

  always @(negedge clock) begin
    if (pushout === 1'b1) begin
      q_data.push_back(dataout);
      q_bits.push_back(bitsout);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_field(input logic [3:0] len, input logic [14:0] d);
    int n = 0;
    while (stopout === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL push_wait stopout=%b required 0 within 200 cycles", stopout);
    end
    pushin = 1'b1;
    lenin  = len;
    datain = d;
    tick();
    pushin = 1'b0;
    lenin  = '0;
    datain = '0;
  endtask

  task automatic wait_words(input int n);
    int k = 0;
    while (q_data.size() < n && k < 300) begin
      tick();
      k++;
    end
    repeat (4) tick();
  endtask

  task automatic clear_q();
    q_data.delete();
    q_bits.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; pushin = 1'b1; lenin = 4'd15; datain = 15'h7FFF;
    flushin = 1'b0; stopin = 1'b0;
    tick();
    tick();
    checks++; if (pushout !== 1'b0) begin errors++; $display("FAIL reset_pushout got %b required 0", pushout); end
    checks++; if (dataout !== 32'h0) begin errors++; $display("FAIL reset_dataout got %h required 0", dataout); end
    checks++; if (bitsout !== 6'd0) begin errors++; $display("FAIL reset_bitsout got %0d required 0", bitsout); end
    checks++; if (stopout !== 1'b0) begin errors++; $display("FAIL reset_stopout got %b required 0", stopout); end
`ifdef BIT_PACKER_ERR_EN
    checks++; if (errout !== 1'b0) begin errors++; $display("FAIL reset_errout got %b required 0", errout); end
`endif
    reset = 1'b0; pushin = 1'b0; lenin = '0; datain = '0;
    clear_q();
    repeat (10) tick();
    checks++; if (q_data.size() != 0) begin errors++; $display("FAIL reset_no_word got %0d words required 0", q_data.size()); end
  endtask

  task automatic test_ones();
    clear_q();
    for (int i = 0; i < 32; i++) push_field(4'd1, 15'h1);
    checks++; if (stopout !== 1'b1) begin errors++; $display("FAIL ones_stall got stopout=%b required 1", stopout); end
    checks++; if (pushout !== 1'b0) begin errors++; $display("FAIL ones_lat_e0 got pushout=%b required 0", pushout); end
    tick();
    checks++; if (stopout !== 1'b0) begin errors++; $display("FAIL ones_one_stall got stopout=%b required 0", stopout); end
    checks++; if (pushout !== 1'b0) begin errors++; $display("FAIL ones_lat_e1 got pushout=%b required 0", pushout); end
    tick();
    checks++; if (pushout !== 1'b1) begin errors++; $display("FAIL ones_lat_e2 got pushout=%b required 1", pushout); end
    checks++; if (dataout !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ones_data got %h required ffffffff", dataout); end
    checks++; if (bitsout !== 6'd32) begin errors++; $display("FAIL ones_bits got %0d required 32", bitsout); end
    wait_words(1);
    checks++; if (q_data.size() != 1) begin errors++; $display("FAIL ones_count got %0d required 1", q_data.size()); end
  endtask

  task automatic test_mixed_flush();
    clear_q();
    push_field(4'd15, 15'h7FFF);
    push_field(4'd15, 15'h0000);
    push_field(4'd4, 15'h000A);
    flushin = 1'b1;
    tick();
    flushin = 1'b0;
    wait_words(2);
    checks++; if (q_data.size() != 2) begin errors++; $display("FAIL mixed_count got %0d required 2", q_data.size()); end
    checks++; if (q_data[0] !== 32'hFFFE_0002) begin errors++; $display("FAIL mixed_w0 got %h required fffe0002", q_data[0]); end
    checks++; if (q_bits[0] !== 6'd32) begin errors++; $display("FAIL mixed_b0 got %0d required 32", q_bits[0]); end
    checks++; if (q_data[1] !== 32'h8000_0000) begin errors++; $display("FAIL flush_w1 got %h required 80000000", q_data[1]); end
    checks++; if (q_bits[1] !== 6'd2) begin errors++; $display("FAIL flush_b1 got %0d required 2", q_bits[1]); end
    // flush with nothing accumulated: one pending cycle, no word
    flushin = 1'b1;
    tick();
    flushin = 1'b0;
    checks++; if (stopout !== 1'b1) begin errors++; $display("FAIL empty_flush_pend got %b required 1", stopout); end
    tick();
    checks++; if (stopout !== 1'b0) begin errors++; $display("FAIL empty_flush_clear got %b required 0", stopout); end
    repeat (6) tick();
    checks++; if (q_data.size() != 2) begin errors++; $display("FAIL empty_flush_noword got %0d required 2", q_data.size()); end
  endtask

  task automatic test_mask();
    clear_q();
    push_field(4'd4, 15'h7FF5);
    push_field(4'd0, 15'h1234);
    for (int i = 0; i < 7; i++) push_field(4'd4, 15'h0);
    push_field(4'd4, 15'hF);
    flushin = 1'b1;
    tick();
    flushin = 1'b0;
    wait_words(2);
    checks++; if (q_data.size() != 2) begin errors++; $display("FAIL mask_count got %0d required 2", q_data.size()); end
    checks++; if (q_data[0] !== 32'h5000_0000) begin errors++; $display("FAIL mask_w0 got %h required 50000000", q_data[0]); end
    checks++; if (q_bits[0] !== 6'd32) begin errors++; $display("FAIL mask_b0 got %0d required 32", q_bits[0]); end
    checks++; if (q_data[1] !== 32'hF000_0000) begin errors++; $display("FAIL mask_w1 got %h required f0000000", q_data[1]); end
    checks++; if (q_bits[1] !== 6'd4) begin errors++; $display("FAIL mask_b1 got %0d required 4", q_bits[1]); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    clear_q();
    stopin = 1'b1;
    for (int w = 0; w < 5; w++)
      for (int j = 0; j < 4; j++) push_field(4'd8, 15'(w * 16 + j));
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (stopout !== 1'b1) begin errors++; $display("FAIL bp_stopout cycle %0d got %b required 1", c, stopout); end
    end
    checks++; if (dut.u_fifo.full_o !== 1'b1) begin errors++; $display("FAIL bp_fifo_full got %b required 1", dut.u_fifo.full_o); end
    checks++; if (q_data.size() != 0) begin errors++; $display("FAIL bp_held got %0d words required 0", q_data.size()); end
    stopin = 1'b0;
    for (int w = 5; w < 7; w++)
      for (int j = 0; j < 4; j++) push_field(4'd8, 15'(w * 16 + j));
    wait_words(7);
    checks++; if (q_data.size() != 7) begin errors++; $display("FAIL bp_count got %0d required 7", q_data.size()); end
    for (int w = 0; w < 7; w++) begin
      exp = {8'(w * 16), 8'(w * 16 + 1), 8'(w * 16 + 2), 8'(w * 16 + 3)};
      checks++;
      if (q_data[w] !== exp || q_bits[w] !== 6'd32) begin
        errors++;
        $display("FAIL bp_word%0d got %h/%0d required %h/32", w, q_data[w], q_bits[w], exp);
      end
    end
  endtask

  task automatic test_error_and_reset();
    clear_q();
    push_field(4'd15, 15'h0);
    push_field(4'd15, 15'h0);
    push_field(4'd2, 15'h0);
    checks++; if (stopout !== 1'b1) begin errors++; $display("FAIL err_stall got %b required 1", stopout); end
`ifdef BIT_PACKER_ERR_EN
    checks++; if (errout !== 1'b0) begin errors++; $display("FAIL err_before got %b required 0", errout); end
`endif
    pushin = 1'b1; lenin = 4'd15; datain = 15'h7FFF;
    tick();
    pushin = 1'b0; lenin = '0; datain = '0;
`ifdef BIT_PACKER_ERR_EN
    checks++; if (errout !== 1'b1) begin errors++; $display("FAIL err_set got %b required 1", errout); end
`endif
    push_field(4'd15, 15'h0);
    push_field(4'd15, 15'h0);
    push_field(4'd2, 15'h0);
    wait_words(2);
`ifdef BIT_PACKER_ERR_EN
    checks++; if (errout !== 1'b1) begin errors++; $display("FAIL err_sticky got %b required 1", errout); end
`endif
    checks++; if (q_data.size() != 2) begin errors++; $display("FAIL err_count got %0d required 2", q_data.size()); end
    checks++; if (q_data[0] !== 32'h0 || q_data[1] !== 32'h0) begin errors++; $display("FAIL err_dropped got %h %h required 0 0", q_data[0], q_data[1]); end

    clear_q();
    push_field(4'd15, 15'h7FFF);
    push_field(4'd5, 15'h1F);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`ifdef BIT_PACKER_ERR_EN
    checks++; if (errout !== 1'b0) begin errors++; $display("FAIL err_reset got %b required 0", errout); end
`endif
    push_field(4'd8, 15'hA5);
    push_field(4'd8, 15'h3C);
    push_field(4'd8, 15'h0F);
    push_field(4'd8, 15'h96);
    wait_words(1);
    checks++; if (q_data.size() != 1) begin errors++; $display("FAIL midrst_count got %0d required 1", q_data.size()); end
    checks++; if (q_data[0] !== 32'hA53C_0F96) begin errors++; $display("FAIL midrst_word got %h required a53c0f96", q_data[0]); end
    checks++; if (q_bits[0] !== 6'd32) begin errors++; $display("FAIL midrst_bits got %0d required 32", q_bits[0]); end
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; pushin = 1'b0; lenin = '0; datain = '0; flushin = 1'b0; stopin = 1'b0;
    test_reset();
    test_ones();
    test_mixed_flush();
    test_mask();
    test_backpressure();
    test_error_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
